fifo_param: RTL and testbench
=============================

FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 8, data bits per entry
- DEPTH, 4, entries; power of two, 2..256
- AF_LEVEL, DEPTH-1, almost_full threshold; legal range 1..DEPTH
- AE_LEVEL, 1, almost_empty threshold; legal range 0..DEPTH-1
- SYNC_OUT, 0, 1 = registered dout and status

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. CW = log2(DEPTH).
- cp2  in  1  clock, rising edge
- ireset  in  1  asynchronous active-low reset
- din  in  WIDTH  write data
- we  in  1  write request
- re  in  1  read request (pop)
- flush  in  1  synchronous clear
- err_clr  in  1  clears error flags (present only with FIFO_ERR_FLAGS_EN)
- dout  out  WIDTH  head-of-queue data (show-ahead)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  CW+1  occupancy, 0..DEPTH
- overflow  out  1  sticky write-while-full (FIFO_ERR_FLAGS_EN only)
- underflow  out  1  sticky read-while-empty (FIFO_ERR_FLAGS_EN only)

REQ-003 The block SHALL use one clock, cp2; ireset SHALL be asynchronous and active-low.

Function
REQ-004 Read and write pointers SHALL be CW+1 bits wide; the low CW bits SHALL address memory, and the MSB SHALL be the wrap bit.
REQ-005 count SHALL equal w_pnt - r_pnt modulo 2^(CW+1); full and empty SHALL derive from the pointers, not from count.
REQ-006 A write SHALL be accepted iff we=1 and full=0; mem[w_pnt] <= din and w_pnt increments.
REQ-007 A read SHALL be accepted iff re=1 and empty=0; r_pnt increments.
REQ-008 Simultaneous we and re: when neither full nor empty, both SHALL be accepted and count SHALL be unchanged. When empty, only the write SHALL be accepted. When full, only the read SHALL be accepted; there is no full-bypass.
REQ-009 Wrap-around: pointers SHALL roll from 2^(CW+1)-1 to 0 with no data loss.
REQ-010 SYNC_OUT=0: dout SHALL be combinational mem[r_pnt], forced to 0 while empty; all flags SHALL be combinational from the pointers; write-to-visible latency is 1 cycle.
REQ-011 SYNC_OUT=1: dout, full, empty, almost_full, almost_empty and count SHALL each be registered one cycle after the REQ-010 values; dout SHALL register 0 while empty; write-to-visible latency is 2 cycles.
REQ-012 Under SYNC_OUT=1, accept decisions SHALL still use the unregistered internal full/empty.
REQ-013 flush=1 SHALL zero both pointers on the next edge, overriding we and re in the same cycle; memory contents SHALL be retained but unreachable.

Reset
REQ-014 ireset=0 SHALL immediately force: pointers 0, memory 0, dout 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, including all SYNC_OUT registers.
REQ-015 Reset asserted mid-transfer SHALL discard the in-flight write or read; the first edge after release SHALL behave as the first operation on an empty FIFO.

Configuration
REQ-016 Macro FIFO_ERR_FLAGS_EN defined: err_clr, overflow and underflow SHALL exist.
- overflow sets on we & full & !flush.
- underflow sets on re & empty & !flush.
- Both clear on err_clr or flush.
- Set SHALL win over a same-cycle err_clr.
REQ-017 FIFO_ERR_FLAGS_EN undefined: those three ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1, SYNC_OUT=0 unless noted)
REQ-018 Write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_empty drops at count 2; almost_full rises at count 3; full=1 at 4; dout=0x11 throughout.
REQ-019 Full, then we=1 din=0x55 -> count stays 4, 0x55 discarded, overflow=1; err_clr=1 one cycle -> overflow=0.
REQ-020 Ten cycles of push/pop, first push alone then we=re=1 with din=0x01..0x0A -> pointers wrap, count constant at 1, dout sequence 0x01..0x0A in order.
REQ-021 Count=2, then flush=1 with we=1 din=0x77 -> count 0, empty 1, dout 0x00, 0x77 not stored.
REQ-022 SYNC_OUT=1, write 0xA5 into empty FIFO -> empty falls and dout=0xA5 two edges after the write edge, not one.
REQ-023 ireset pulsed low between edges with count=3 -> all outputs take REQ-014 values immediately without a clock edge.

Source files
------------

// File: rtl/fifo_param.sv
// -----------------------------------------------------------------------------
// fifo_param -- synchronous single-clock FIFO with show-ahead output.
//
// Parameters
//   WIDTH     data bits per entry
//   DEPTH     number of entries (power of two, 2..256)
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//   SYNC_OUT  0: dout/status are combinational from the pointers
//             1: dout/status are registered one cycle later
//
// Optional feature macro: FIFO_ERR_FLAGS_EN adds err_clr, overflow and
// underflow. Without it those ports and their logic do not exist.
//
// Ports
//   cp2           clock, rising edge
//   ireset        asynchronous active-low reset
//   din, we       write data / write request
//   re            read request (pop of the head entry)
//   flush         synchronous clear of both pointers
//   err_clr       clears the sticky error flags (FIFO_ERR_FLAGS_EN)
//   dout          head-of-queue data, 0 while empty
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow      sticky write-while-full (FIFO_ERR_FLAGS_EN)
//   underflow     sticky read-while-empty (FIFO_ERR_FLAGS_EN)
//
// Handshake: we and re are requests, not valid/ready pairs. A write is
// accepted on a rising edge iff we=1, the FIFO is not full and flush=0; a
// read is accepted iff re=1, the FIFO is not empty and flush=0. Requests
// that are not accepted are dropped (and flagged when error flags exist).
// -----------------------------------------------------------------------------
module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int SYNC_OUT = 0,
  localparam int CW      = $clog2(DEPTH)
) (
  input  logic             cp2,
  input  logic             ireset,
  input  logic [WIDTH-1:0] din,
  input  logic             we,
  input  logic             re,
  input  logic             flush,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow,
`endif
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW:0]      count
);

  localparam logic [CW:0] AF_THR = (CW+1)'(AF_LEVEL);
  localparam logic [CW:0] AE_THR = (CW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the address bits match.
  logic [CW:0]      w_pnt;
  logic [CW:0]      r_pnt;

  logic             full_i;
  logic             empty_i;
  logic             af_i;
  logic             ae_i;
  logic [CW:0]      count_i;
  logic [WIDTH-1:0] dout_i;
  logic             wr_acc;
  logic             rd_acc;

  always_comb begin
    empty_i = (w_pnt == r_pnt);
    full_i  = (w_pnt[CW] != r_pnt[CW]) && (w_pnt[CW-1:0] == r_pnt[CW-1:0]);
    count_i = w_pnt - r_pnt;
    af_i    = (count_i >= AF_THR);
    ae_i    = (count_i <= AE_THR);
    dout_i  = empty_i ? '0 : mem[r_pnt[CW-1:0]];
    // Accept decisions always use the internal (unregistered) status.
    wr_acc  = we & ~full_i & ~flush;
    rd_acc  = re & ~empty_i & ~flush;
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_acc) begin
      mem[w_pnt[CW-1:0]] <= din;
    end
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      w_pnt <= '0;
      r_pnt <= '0;
    end else if (flush) begin
      // Memory keeps its contents; they become unreachable.
      w_pnt <= '0;
      r_pnt <= '0;
    end else begin
      if (wr_acc) w_pnt <= w_pnt + 1'b1;
      if (rd_acc) r_pnt <= r_pnt + 1'b1;
    end
  end

  generate
    if (SYNC_OUT != 0) begin : g_sync
      always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
          dout         <= '0;
          full         <= 1'b0;
          empty        <= 1'b1;
          almost_full  <= 1'b0;
          almost_empty <= 1'b1;
          count        <= '0;
        end else begin
          dout         <= dout_i;
          full         <= full_i;
          empty        <= empty_i;
          almost_full  <= af_i;
          almost_empty <= ae_i;
          count        <= count_i;
        end
      end
    end else begin : g_comb
      assign dout         = dout_i;
      assign full         = full_i;
      assign empty        = empty_i;
      assign almost_full  = af_i;
      assign almost_empty = ae_i;
      assign count        = count_i;
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  // A new error event wins over a same-cycle err_clr; flush suppresses the
  // event and clears the flag.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we & full_i & ~flush)    overflow <= 1'b1;
      else if (err_clr | flush)    overflow <= 1'b0;
      if (re & empty_i & ~flush)   underflow <= 1'b1;
      else if (err_clr | flush)    underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: two instances (SYNC_OUT=0 and SYNC_OUT=1) share the
// same stimulus. A queue model gives the combinational view; a one-cycle
// snapshot of it gives the registered view.
module tb_fifo_param;

  localparam int W = 8;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic cp2 = 1'b0;
  logic rst_n = 1'b0;
  always #5 cp2 = ~cp2;

  logic [W-1:0] din = '0;
  logic we = 1'b0, re = 1'b0, flush = 1'b0, err_clr = 1'b0;

  logic [W-1:0] a_dout, s_dout;
  logic a_full, a_empty, a_af, a_ae, s_full, s_empty, s_af, s_ae;
  logic [2:0] a_count, s_count;
  logic a_ovf, a_unf, s_ovf, s_unf;

  fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(3), .AE_LEVEL(1), .SYNC_OUT(0)) u_dut (
    .cp2(cp2), .ireset(rst_n), .din(din), .we(we), .re(re), .flush(flush),
`ifdef FIFO_ERR_FLAGS_EN
    .err_clr(err_clr), .overflow(a_ovf), .underflow(a_unf),
`endif
    .dout(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .count(a_count)
  );

  fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(3), .AE_LEVEL(1), .SYNC_OUT(1)) u_sync (
    .cp2(cp2), .ireset(rst_n), .din(din), .we(we), .re(re), .flush(flush),
`ifdef FIFO_ERR_FLAGS_EN
    .err_clr(err_clr), .overflow(s_ovf), .underflow(s_unf),
`endif
    .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count)
  );

`ifndef FIFO_ERR_FLAGS_EN
  assign a_ovf = 1'b0;
  assign a_unf = 1'b0;
  assign s_ovf = 1'b0;
  assign s_unf = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFO contents as a queue.
  logic [W-1:0] exp_q[$];
  bit m_ovf = 1'b0, m_unf = 1'b0;
  // Registered view: what the combinational view was before the last edge.
  logic [W-1:0] r_dout = '0;
  int r_cnt = 0;

  function automatic logic [W-1:0] head_val();
    return (exp_q.size() == 0) ? '0 : exp_q[0];
  endfunction

  always @(posedge cp2 or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      r_dout = '0;
      r_cnt = 0;
    end else begin
      int sz;
      sz = exp_q.size();
      r_dout = head_val();
      r_cnt = sz;
      if (we && sz == D && !flush)      m_ovf = 1'b1;
      else if (err_clr || flush)        m_ovf = 1'b0;
      if (re && sz == 0 && !flush)      m_unf = 1'b1;
      else if (err_clr || flush)        m_unf = 1'b0;
      if (flush) begin
        exp_q.delete();
      end else begin
        bit wa, ra;
        wa = we && (sz != D);
        ra = re && (sz != 0);
        if (ra) void'(exp_q.pop_front());
        if (wa) exp_q.push_back(din);
      end
    end
  end

  // One compare process, every cycle, away from the active edge.
  always @(negedge cp2) begin
    if (chk_en) begin
      int sz;
      sz = exp_q.size();
      chk("c_count", 32'(a_count), 32'(sz));
      chk("c_empty", 32'(a_empty), 32'(sz == 0));
      chk("c_full",  32'(a_full),  32'(sz == D));
      chk("c_af",    32'(a_af),    32'(sz >= 3));
      chk("c_ae",    32'(a_ae),    32'(sz <= 1));
      chk("c_dout",  32'(a_dout),  32'(head_val()));
      chk("s_count", 32'(s_count), 32'(r_cnt));
      chk("s_empty", 32'(s_empty), 32'(r_cnt == 0));
      chk("s_full",  32'(s_full),  32'(r_cnt == D));
      chk("s_af",    32'(s_af),    32'(r_cnt >= 3));
      chk("s_ae",    32'(s_ae),    32'(r_cnt <= 1));
      chk("s_dout",  32'(s_dout),  32'(r_dout));
`ifdef FIFO_ERR_FLAGS_EN
      chk("c_ovf", 32'(a_ovf), 32'(m_ovf));
      chk("c_unf", 32'(a_unf), 32'(m_unf));
      chk("s_ovf", 32'(s_ovf), 32'(m_ovf));
      chk("s_unf", 32'(s_unf), 32'(m_unf));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge cp2);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_c_count"}, 32'(a_count), 0);
    chk({tag, "_c_empty"}, 32'(a_empty), 1);
    chk({tag, "_c_full"},  32'(a_full),  0);
    chk({tag, "_c_ae"},    32'(a_ae),    1);
    chk({tag, "_c_af"},    32'(a_af),    0);
    chk({tag, "_c_dout"},  32'(a_dout),  0);
    chk({tag, "_s_count"}, 32'(s_count), 0);
    chk({tag, "_s_empty"}, 32'(s_empty), 1);
    chk({tag, "_s_full"},  32'(s_full),  0);
    chk({tag, "_s_ae"},    32'(s_ae),    1);
    chk({tag, "_s_af"},    32'(s_af),    0);
    chk({tag, "_s_dout"},  32'(s_dout),  0);
    chk({tag, "_ovf"},     32'(a_ovf),   0);
    chk({tag, "_unf"},     32'(a_unf),   0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle();
    rst_n = 1'b0;
    step();
    step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Fill with 0x11..0x44.
    for (int i = 0; i < 4; i++) begin
      din = 8'(8'h11 * (i + 1));
      we = 1'b1;
      step();
      chk("fill_count", 32'(a_count), 32'(i + 1));
      chk("fill_ae",    32'(a_ae),    32'(i == 0));
      chk("fill_af",    32'(a_af),    32'(i >= 2));
      chk("fill_full",  32'(a_full),  32'(i == 3));
      chk("fill_dout",  32'(a_dout),  32'h11);
    end

    // Write while full is dropped.
    din = 8'h55;
    step();
    chk("ovf_count", 32'(a_count), 4);
    chk("ovf_dout",  32'(a_dout),  32'h11);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_set", 32'(a_ovf), 1);
    we = 1'b0; err_clr = 1'b1;
    step();
    chk("ovf_clr", 32'(a_ovf), 0);
    err_clr = 1'b0;
`endif

    // Drain in order; 0x55 must not appear.
    we = 1'b0; re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_dout", 32'(a_dout), 32'(8'h11 * (i + 1)));
      step();
    end
    chk("drain_empty", 32'(a_empty), 1);
    chk("drain_dout0", 32'(a_dout),  0);
    step();              // read while empty
    idle();

    // Streaming push/pop across pointer wrap.
    din = 8'h01; we = 1'b1;
    step();
    chk("strm_first", 32'(a_dout), 32'h01);
    re = 1'b1;
    for (int k = 2; k <= 10; k++) begin
      din = 8'(k);
      step();
      chk("strm_count", 32'(a_count), 1);
      chk("strm_dout",  32'(a_dout),  32'(k));
    end
    idle();

    // Flush overrides a same-cycle write.
    din = 8'h22; we = 1'b1;
    step();
    chk("fl_pre_count", 32'(a_count), 2);
    din = 8'h77; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_count", 32'(a_count), 0);
    chk("fl_empty", 32'(a_empty), 1);
    chk("fl_dout",  32'(a_dout),  0);

    // Registered outputs: visible two edges after the write edge.
    din = 8'hA5;
    step();
    we = 1'b0;
    chk("sync_e1_empty", 32'(s_empty), 1);
    chk("sync_e1_dout",  32'(s_dout),  0);
    chk("comb_e1_dout",  32'(a_dout),  32'hA5);
    step();
    chk("sync_e2_empty", 32'(s_empty), 0);
    chk("sync_e2_dout",  32'(s_dout),  32'hA5);
    chk("sync_e2_count", 32'(s_count), 1);

    // Async reset between edges with count=3.
    we = 1'b1; din = 8'h5A;
    step();
    din = 8'hC3;
    step();
    idle();
    chk("ar_pre_count", 32'(a_count), 3);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    #1 rst_n = 1'b1;
    step();
    chk("ar_post_empty", 32'(a_empty), 1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      we      = ($urandom_range(0, 3) != 0);
      re      = ($urandom_range(0, 2) == 0) ? ~we : 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 40) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      din     = 8'($urandom_range(0, 255));
      step();
    end
    idle();
    step();
    step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
